// File: rtl/f_measure_mc.sv
// f_measure_mc: multi-channel edge-gated reciprocal frequency meter with auto-ranging
module f_measure_mc #(
  parameter int CLK_HZ   = 10_000_000,
  parameter int W        = 26,
  parameter int NCH      = 3,
  parameter int FILT0    = 200,
  parameter int FSHIFT   = 5,
  parameter int GATE_CYC = 1_000_000,
  parameter int TMO_CYC  = 2_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   signal_in,
  output logic [W-1:0]           freq,
  output logic [$clog2(NCH)-1:0] range_sel,
  output logic                   no_signal,
  output logic                   f_update
);
  localparam int RW = $clog2(NCH);
  localparam int DW = W + $clog2(CLK_HZ + 1);
  localparam int CW = $clog2(DW + 1);
  localparam int LW = $clog2(FILT0 + 2);
  localparam int TW = $clog2((GATE_CYC > TMO_CYC ? GATE_CYC : TMO_CYC) + 1);
  localparam logic [W-1:0] MAXV = '1;
  localparam logic [DW-1:0] CK = DW'(CLK_HZ);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DIV, S_SEL, S_UPD} state_t;
  function automatic int flen(input int k);
    return (k == NCH - 1) ? 0 : FILT0 >> (FSHIFT * k);
  endfunction
  function automatic logic [W-1:0] fmax(input int k);
    return flen(k) == 0 ? MAXV : W'(CLK_HZ / (3 * (flen(k) == 0 ? 1 : flen(k))));
  endfunction
  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic [NCH-1:0] filt_q, prev_q, gate_q, done_q, inv_q, rise;
  logic [LW-1:0] fcnt_q [NCH];
  logic [W-1:0] m_q [NCH];
  logic [W-1:0] n_q [NCH];
  logic [W-1:0] res_q [NCH];
  logic [TW-1:0] tm_q;
  logic [RW-1:0] k_q, sel_q, sel_d;
  logic [CW-1:0] bit_q;
  logic [DW-1:0] dv_q, dv_d;
  logic [W-1:0] rem_q, rem_d, res_d;
  logic [W:0] rem_sh;
  logic req, live, ge, bad, all_zero;
  // sequence state register
  always_ff @(posedge clk) state_q <= rst ? S_IDLE : state_d;
  // measurement sequencing: gate request, edge wait, per-channel division, selection, publish
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ:  state_d = (tm_q == TW'(GATE_CYC - 1)) ? S_WAIT : S_REQ;
      S_WAIT: state_d = (&done_q || tm_q == TW'(TMO_CYC - 1)) ? S_DIV : S_WAIT;
      S_DIV:  state_d = (bit_q == CW'(DW) && k_q == RW'(NCH - 1)) ? S_SEL : S_DIV;
      S_SEL:  state_d = S_UPD;
      default: state_d = S_IDLE;
    endcase
  end
  // gate request and counting window decoded from the state
  always_comb begin
    req  = state_q == S_REQ;
    live = state_q == S_REQ || state_q == S_WAIT;
    rise = filt_q & ~prev_q;
  end
  // phase timer restarts on every state change
  always_ff @(posedge clk) tm_q <= (rst || state_d != state_q) ? '0 : tm_q + 1'b1;
  // synchronizer and per-channel persistence filters; length 0 just follows the synchronizer
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      filt_q <= '0;
      prev_q <= '0;
      for (int i = 0; i < NCH; i++) fcnt_q[i] <= '0;
    end else begin
      sync_q <= {sync_q[0], signal_in};
      prev_q <= filt_q;
      for (int i = 0; i < NCH; i++) begin
        if (flen(i) == 0 || (sync_q[1] != filt_q[i] && fcnt_q[i] == LW'(flen(i) - 1))) begin
          filt_q[i] <= sync_q[1];
          fcnt_q[i] <= '0;
        end else fcnt_q[i] <= (sync_q[1] != filt_q[i]) ? fcnt_q[i] + 1'b1 : '0;
      end
    end
  end
  // edge-aligned gates with saturating period (M) and edge (N) counters
  always_ff @(posedge clk) begin
    if (rst || state_q == S_IDLE) begin
      gate_q <= '0;
      done_q <= '0;
      inv_q  <= '0;
      for (int i = 0; i < NCH; i++) begin
        m_q[i] <= '0;
        n_q[i] <= '0;
      end
    end else begin
      if (state_q == S_WAIT && state_d == S_DIV) inv_q <= inv_q | ~done_q;
      for (int i = 0; i < NCH; i++) begin
        if (live) begin
          if (rise[i] && req && !gate_q[i] && !done_q[i]) gate_q[i] <= 1'b1;
          if (rise[i] && !req && gate_q[i]) begin
            gate_q[i] <= 1'b0;
            done_q[i] <= 1'b1;
          end
          if (gate_q[i] && m_q[i] != MAXV) m_q[i] <= m_q[i] + 1'b1;
          if (gate_q[i] && rise[i] && n_q[i] != MAXV) n_q[i] <= n_q[i] + 1'b1;
        end
      end
    end
  end
  // one restoring step; the quotient shifts in where the dividend shifts out
  always_comb begin
    rem_sh = {rem_q, dv_q[DW-1]};
    ge     = rem_sh >= {1'b0, m_q[k_q]};
    rem_d  = ge ? W'(rem_sh - {1'b0, m_q[k_q]}) : rem_sh[W-1:0];
    dv_d   = {dv_q[DW-2:0], ge};
    bad    = inv_q[k_q] || m_q[k_q] == '0 || n_q[k_q] == '0 || m_q[k_q] == MAXV || n_q[k_q] == MAXV;
    res_d  = bad ? '0 : (|dv_d[DW-1:W]) ? MAXV : dv_d[W-1:0];
  end
  // shared divider: a load cycle then DW quotient bits per channel
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q   <= '0;
      bit_q <= '0;
      dv_q  <= '0;
      rem_q <= '0;
      for (int i = 0; i < NCH; i++) res_q[i] <= '0;
    end else if (state_q != S_DIV) begin
      k_q   <= '0;
      bit_q <= '0;
    end else if (bit_q == '0) begin
      dv_q  <= DW'(n_q[k_q]) * CK;
      rem_q <= '0;
      bit_q <= 1'b1;
    end else begin
      dv_q  <= dv_d;
      rem_q <= rem_d;
      bit_q <= (bit_q == CW'(DW)) ? '0 : bit_q + 1'b1;
      if (bit_q == CW'(DW)) begin
        res_q[k_q] <= res_d;
        k_q <= k_q + 1'b1;
      end
    end
  end
  // auto-range: lowest channel whose result is nonzero and below its filter's trust limit
  always_comb begin
    all_zero = 1'b1;
    sel_d = RW'(NCH - 1);
    for (int i = NCH - 1; i >= 0; i--) begin
      if (res_q[i] != '0) all_zero = 1'b0;
      if (res_q[i] != '0 && res_q[i] < fmax(i)) sel_d = RW'(i);
    end
  end
  // publish the selected result with a one-cycle strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q     <= '0;
      freq      <= '0;
      range_sel <= '0;
      no_signal <= 1'b0;
      f_update  <= 1'b0;
    end else begin
      if (state_q == S_SEL) sel_q <= sel_d;
      f_update <= state_q == S_UPD;
      if (state_q == S_UPD) begin
        freq      <= res_q[sel_q];
        range_sel <= sel_q;
        no_signal <= all_zero;
      end
    end
  end
endmodule

// File: tb/tb_f_measure_mc.sv
// tb_f_measure_mc: randomized periodic-input checks of f_measure_mc against a rule-level model
module tb_f_measure_mc;
  localparam int CLK_HZ = 10_000_000, W = 26, NCH = 3, FILT0 = 16, FSHIFT = 2;
  localparam int GATE = 1000, TMO = 1500;
  localparam int DW = W + $clog2(CLK_HZ + 1);
  localparam int MEAS = GATE + TMO + NCH * (DW + 1) + 2;
  logic clk = 1'b0, rst = 1'b1, signal_in = 1'b0;
  logic [W-1:0] freq;
  logic [1:0] range_sel;
  logic no_signal, f_update;
  int checks = 0, errors = 0;
  int per = 0, hi = 0;
  bit glitch = 1'b0, hold_bad = 1'b0;
  logic [W-1:0] last_f = '0;
  f_measure_mc #(.CLK_HZ(CLK_HZ), .W(W), .NCH(NCH), .FILT0(FILT0), .FSHIFT(FSHIFT),
                 .GATE_CYC(GATE), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .signal_in(signal_in), .freq(freq),
    .range_sel(range_sel), .no_signal(no_signal), .f_update(f_update));
  always #5 clk = ~clk;
  // square wave of per cycles, hi cycles high; optional 1-cycle glitches mid-half-period
  initial begin : gen
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      if (per == 0) signal_in = 1'b0;
      else begin
        signal_in = (ph < hi) ^ (glitch && (ph % 100 == 50));
        ph = (ph + 1) % per;
      end
    end
  end
  // a channel passes the wave iff both half-periods reach its filter length
  task automatic model(input int p, input int h, output int f, output int r, output bit ns);
    int res, l, fm;
    bit found;
    f = 0; r = NCH - 1; ns = 1'b1; found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      l = (k == NCH - 1) ? 0 : FILT0 >> (FSHIFT * k);
      res = (p > 0 && h >= l && p - h >= l) ? CLK_HZ / p : 0;
      fm = (l == 0) ? (1 << W) - 1 : CLK_HZ / (3 * l);
      if (res != 0) ns = 1'b0;
      if (!found && res > 0 && res < fm) begin
        found = 1'b1; r = k; f = res;
      end else if (!found && k == NCH - 1) f = res;
    end
  endtask
  task automatic wait_upd(output bit ok, output int cyc);
    ok = 1'b0; cyc = 0;
    while (!ok && cyc < 2 * MEAS) begin
      @(negedge clk);
      cyc++;
      if (f_update) ok = 1'b1;
      else if (freq !== last_f) hold_bad = 1'b1;
    end
    if (ok) last_f = freq;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (freq !== '0) begin errors++; $display("FAIL reset_freq got %0d want 0", freq); end
    checks++; if (range_sel !== 2'd0) begin errors++; $display("FAIL reset_range got %0d want 0", range_sel); end
    checks++; if (no_signal !== 1'b0) begin errors++; $display("FAIL reset_nosig got %b want 0", no_signal); end
    checks++; if (f_update !== 1'b0) begin errors++; $display("FAIL reset_upd got %b want 0", f_update); end
    rst = 1'b0;
    last_f = '0;
  endtask
  task automatic test_no_signal;
    int ef, er, c;
    bit ens, ok;
    per = 0; glitch = 1'b0;
    model(0, 0, ef, er, ens);
    wait_upd(ok, c);
    for (int rep = 0; rep < 2; rep++) begin
      wait_upd(ok, c);
      checks++;
      if (!ok) begin errors++; $display("FAIL nosig_timeout no f_update within %0d cycles", c); end
      else begin
        checks++; if (int'(freq) != ef) begin errors++; $display("FAIL nosig_freq got %0d want %0d", freq, ef); end
        checks++; if (int'(range_sel) != er) begin errors++; $display("FAIL nosig_range got %0d want %0d", range_sel, er); end
        checks++; if (no_signal !== ens) begin errors++; $display("FAIL nosig_flag got %b want %b", no_signal, ens); end
        checks++;
        if (c < GATE + TMO || c > MEAS + 4) begin
          errors++; $display("FAIL nosig_interval got %0d want %0d..%0d", c, GATE + TMO, MEAS + 4);
        end
      end
    end
  endtask
  task automatic test_reset_div;
    int c, n;
    bit ok;
    per = 0;
    wait_upd(ok, c);
    checks++; if (!ok) begin errors++; $display("FAIL rdiv_sync no f_update within %0d cycles", c); end
    repeat (GATE + TMO + 50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_f = '0;
    checks++; if (freq !== '0) begin errors++; $display("FAIL rdiv_freq got %0d want 0", freq); end
    checks++; if (range_sel !== 2'd0) begin errors++; $display("FAIL rdiv_range got %0d want 0", range_sel); end
    checks++; if (no_signal !== 1'b0) begin errors++; $display("FAIL rdiv_nosig got %b want 0", no_signal); end
    n = 0;
    for (int i = 0; i < GATE + TMO - 5; i++) begin
      @(negedge clk);
      if (f_update) n++;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL rdiv_early_upd got %0d strobes want 0", n); end
    wait_upd(ok, c);
    checks++;
    if (!ok) begin errors++; $display("FAIL rdiv_timeout no f_update within %0d cycles", c); end
    else if (no_signal !== 1'b1 || range_sel !== 2'd2 || freq !== '0) begin
      errors++; $display("FAIL rdiv_after got f=%0d r=%0d ns=%b want 0/2/1", freq, range_sel, no_signal);
    end
  endtask
  task automatic test_random(input int n);
    int p, h, ef, er, band, c;
    bit ens, ok;
    for (int t = 0; t < n; t++) begin
      band = $urandom_range(0, 2);
      p = band == 0 ? $urandom_range(64, 600) : band == 1 ? $urandom_range(14, 30) : $urandom_range(2, 7);
      h = p / 2;
      per = p; hi = h; glitch = 1'b0;
      model(p, h, ef, er, ens);
      wait_upd(ok, c);
      for (int rep = 0; rep < 2; rep++) begin
        wait_upd(ok, c);
        checks++;
        if (!ok) begin errors++; $display("FAIL rand_timeout p=%0d no f_update within %0d cycles", p, c); end
        else begin
          checks++;
          if (int'(freq) > ef + 1 || int'(freq) < ef - 1) begin
            errors++; $display("FAIL rand_freq p=%0d got %0d want %0d+-1", p, freq, ef);
          end
          checks++; if (int'(range_sel) != er) begin errors++; $display("FAIL rand_range p=%0d got %0d want %0d", p, range_sel, er); end
          checks++; if (no_signal !== ens) begin errors++; $display("FAIL rand_nosig p=%0d got %b want %b", p, no_signal, ens); end
          @(negedge clk);
          checks++; if (f_update !== 1'b0) begin errors++; $display("FAIL rand_pulse p=%0d strobe longer than 1 cycle", p); end
        end
      end
    end
  endtask
  task automatic test_glitch;
    int ef, er, c;
    bit ens, ok;
    per = 400; hi = 200; glitch = 1'b1;
    model(400, 200, ef, er, ens);
    wait_upd(ok, c);
    wait_upd(ok, c);
    checks++;
    if (!ok) begin errors++; $display("FAIL glitch_timeout no f_update within %0d cycles", c); end
    else begin
      checks++;
      if (int'(freq) > ef + 1 || int'(freq) < ef - 1) begin
        errors++; $display("FAIL glitch_freq got %0d want %0d+-1", freq, ef);
      end
      checks++; if (int'(range_sel) != er) begin errors++; $display("FAIL glitch_range got %0d want %0d", range_sel, er); end
    end
    glitch = 1'b0;
  endtask
  task automatic test_hold;
    checks++;
    if (hold_bad) begin errors++; $display("FAIL hold freq changed outside f_update got 1 want 0"); end
  endtask
  initial begin
    test_reset;
    test_no_signal;
    test_reset_div;
    test_random(5);
    test_glitch;
    test_hold;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/f_measure_mc.md
# f_measure_mc

Multi-channel reciprocal (equal-precision) frequency meter that replaces the fixed three-path meter. It measures one asynchronous input through NCH parallel glitch-filter paths, each with its own length, using a gate aligned to signal edges. A single shared sequential divider turns each path's counts into hertz, and auto-ranging picks the most-filtered path whose result is trustworthy. It sits between the input conditioning and the display/range logic of the multimeter.

## Interface
- CLK_HZ, 10_000_000: clk frequency in Hz; numerator constant.
- W, 26: width of counters and of `freq`.
- NCH, 3: number of channels, ≥2.
- FILT0, 200: filter length of channel 0 in clk cycles.
- FSHIFT, 5: channel k filter length = FILT0 >> (FSHIFT*k); channel NCH-1 is always unfiltered.
- GATE_CYC, 1_000_000: requested gate length in clk cycles.
- TMO_CYC, 2_000_000: wait limit for a closing edge, in clk cycles.
- clk  in  1  system clock. One clock domain.
- rst  in  1  synchronous, active-high reset.
- signal_in  in  1  asynchronous measured signal.
- freq  out  W  selected frequency in Hz; held between updates.
- range_sel  out  max(1,$clog2(NCH))  index of the channel that produced `freq`.
- no_signal  out  1  high when every channel result is 0.
- f_update  out  1  one-cycle strobe: `freq`, `range_sel` and `no_signal` are new this cycle.

## Operation
- Input path: 2-flop synchronizer, then NCH filters. A filter of length L>0 changes its output only after the input has held the new level for L consecutive cycles. L=0 is a pass-through.
- Per channel:
  - Rising-edge detect on the filtered signal.
  - Gate opens at the first rising edge after `req` rises and closes at the first rising edge after `req` falls.
  - M counts clk cycles while the gate is open; N counts rising edges while the gate is open.
  - Both counters saturate at 2^W−1. Saturation marks the channel invalid.
- FSM states:
  - IDLE: clear all M/N counters → REQ.
  - REQ: `req`=1 for GATE_CYC cycles → WAIT.
  - WAIT: stays until every gate is closed, or until TMO_CYC cycles pass. A channel whose gate has not closed by then is invalid. → DIV with k=0.
  - DIV: runs the restoring divider on channel k: quotient = (N·CLK_HZ)/M.
    - Dividend width DW = W+$clog2(CLK_HZ+1), one quotient bit per cycle.
    - Quotient saturates at 2^W−1.
    - Result_k = 0 if the channel is invalid, M=0 or N=0.
    - k increments after each channel; once all NCH channels are done → SEL.
  - SEL: picks the lowest k with 0 < result_k < FMAX_k, where FMAX_k = CLK_HZ/(3·len_k) is an elaboration constant. If none qualifies, picks NCH−1 → UPD.
  - UPD: registers the outputs and pulses `f_update` → IDLE.
- Measurement repeats continuously and needs no external trigger.
- `no_signal`=1 when every result_k = 0; then `freq`=0 and `range_sel`=NCH−1.

## Timing
- Reset (sync, rst=1 at a clk edge):
  - `freq`=0, `range_sel`=0, `no_signal`=0, `f_update`=0.
  - FSM to IDLE; all counters, filters and the divider cleared.
- Reset asserted in any state abandons the cycle with no `f_update`. The first update after release comes one full measurement later.
- Input latency: 2 synchronizer cycles + L_k filter cycles; applies equally to both gate edges, so it cancels out of M.
- From `req` fall to `f_update`: WAIT time (≤ TMO_CYC) + NCH·(DW+1) + 2 cycles.
- `f_update` is high for exactly 1 cycle per measurement. Outputs change only in that cycle.
- An edge arriving in the same cycle `req` rises counts as the opening edge. An edge in the same cycle `req` falls does not close the gate.
- A gate that opens but never closes within TMO_CYC makes that channel invalid, with no hang.
- Wrap-around: all counters saturate and never roll over.

## Test plan
- 1 kHz 50% square, defaults → `f_update` once per measurement, `freq`=1000±1, `range_sel`=0, `no_signal`=0.
- 100 kHz square → ch0 filter suppresses edges so result_0=0; `freq`=100000±1, `range_sel`=1.
- 2 MHz square → ch0 and ch1 both give 0; `freq`=2000000±1, `range_sel`=2.
- signal_in held low → `f_update` pulses after ~GATE_CYC+TMO_CYC cycles, `freq`=0, `no_signal`=1, `range_sel`=2.
- 1 kHz with 50 ns glitches injected every 100 µs → `freq`=1000±1, `range_sel`=0 (the glitches are rejected).
- rst pulsed for one cycle during DIV → no `f_update` that cycle, all outputs 0, next valid update after a full measurement.
